// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the
// single-port RAM behind it.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        err;

  modport master (
    output if_req, if_addr,
    output mem_read, mem_write, mem_addr, mem_wdata,
    output ram_rdata,
    input  if_rdata, if_ready,
    input  mem_rdata, mem_ready,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    input  err
  );

  modport slave (
    input  if_req, if_addr,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    input  ram_rdata,
    output if_rdata, if_ready,
    output mem_rdata, mem_ready,
    output ram_en, ram_we, ram_addr, ram_wdata,
    output err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between instruction fetch and data access,
// favouring data but bounding how long a pending fetch can be starved.
module mem_arbiter #(
  parameter int LATENCY    = 2,
  parameter int STARVE_MAX = 3
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  localparam logic [3:0] SMAX   = 4'(STARVE_MAX);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [3:0]  streak, streak_n;
  logic        own_if, own_if_n;
  logic        wr, wr_n;

  logic        data_req, any_req, pick_if;
  logic        grant, finish, done_n;

  logic        ram_en_q, ram_en_n;
  logic        ram_we_q, ram_we_n;
  logic        if_ready_q, if_ready_n;
  logic        mem_ready_q, mem_ready_n;
  logic        err_q, err_n;
  logic [31:0] ram_addr_q, ram_addr_n;
  logic [31:0] ram_wdata_q, ram_wdata_n;
  logic [31:0] if_rdata_q, if_rdata_n;
  logic [31:0] mem_rdata_q, mem_rdata_n;

  assign data_req = bus.mem_read | bus.mem_write;
  assign any_req  = bus.if_req | data_req;
  assign pick_if  = bus.if_req &
                    (~data_req | (streak == SMAX));
  assign grant    = (state == IDLE) & any_req;
  assign finish   = (state == WAIT) & (cnt == '0);
  assign done_n   = ((state == ISSUE) & wr) | finish;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      streak <= '0;
      own_if <= 1'b0;
      wr     <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      streak <= streak_n;
      own_if <= own_if_n;
      wr     <= wr_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    streak_n = streak;
    own_if_n = own_if;
    wr_n     = wr;
    unique case (state)
      IDLE: begin
        if (!bus.if_req) streak_n = '0;
        if (any_req) begin
          state_n  = ISSUE;
          own_if_n = pick_if;
          // read+write together is resolved as a write
          wr_n     = ~pick_if & bus.mem_write;
          if (pick_if)
            streak_n = '0;
          else if (bus.if_req && streak < SMAX)
            streak_n = streak + 4'd1;
        end
      end
      ISSUE: begin
        if (wr) begin
          state_n = DONE;
        end else begin
          state_n = WAIT;
          cnt_n   = LAT_M1;
        end
      end
      WAIT: begin
        if (cnt == '0) state_n = DONE;
        else           cnt_n   = cnt - 4'd1;
      end
      DONE: state_n = IDLE;
    endcase
  end

  always_comb begin
    ram_en_n    = grant;
    ram_we_n    = grant & ~pick_if & bus.mem_write;
    ram_addr_n  = ram_addr_q;
    ram_wdata_n = ram_wdata_q;
    if (grant) begin
      ram_addr_n  = pick_if ? bus.if_addr : bus.mem_addr;
      ram_wdata_n = pick_if ? ram_wdata_q : bus.mem_wdata;
    end
    if_ready_n  = done_n & own_if;
    mem_ready_n = done_n & ~own_if;
    if_rdata_n  = (finish & own_if) ? bus.ram_rdata : if_rdata_q;
    mem_rdata_n = (finish & ~own_if) ? bus.ram_rdata : mem_rdata_q;
    err_n       = err_q |
                  (grant & ~pick_if & bus.mem_read & bus.mem_write);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      err_q       <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      ram_en_q    <= ram_en_n;
      ram_we_q    <= ram_we_n;
      if_ready_q  <= if_ready_n;
      mem_ready_q <= mem_ready_n;
      err_q       <= err_n;
      ram_addr_q  <= ram_addr_n;
      ram_wdata_q <= ram_wdata_n;
      if_rdata_q  <= if_rdata_n;
      mem_rdata_q <= mem_rdata_n;
    end
  end

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed timing cases, then
// randomized fetch/data traffic against a RAM model and reference memory.
module tb_mem_arbiter;
  localparam int LAT  = 2;
  localparam int SMAX = 3;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] if_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] ref_mem [16];
  logic [31:0] last_rd;

  mem_arbiter_if bus();

  mem_arbiter #(.LATENCY(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 + 32'(i * 7);
  endfunction

  // RAM: data words below 0x40, a fixed pattern elsewhere
  logic [31:0] ram_mem [16];
  logic        ram_init = 1'b0;
  logic [31:0] dsr [LAT];
  logic        vsr [LAT];

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 16; i++) ram_mem[i] <= init_word(i);
      ram_init <= 1'b1;
    end else if (bus.ram_en && bus.ram_we && bus.ram_addr < 32'h40) begin
      ram_mem[bus.ram_addr[5:2]] <= bus.ram_wdata;
    end
    vsr[0] <= bus.ram_en & ~bus.ram_we;
    dsr[0] <= (bus.ram_addr < 32'h40) ?
              ram_mem[bus.ram_addr[5:2]] : rom(bus.ram_addr);
    for (int i = 1; i < LAT; i++) begin
      vsr[i] <= vsr[i-1];
      dsr[i] <= dsr[i-1];
    end
  end

  assign bus.ram_rdata = (vsr[LAT-1] === 1'b1) ?
                         dsr[LAT-1] : 32'h0BAD_0BAD;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_ready(input bit fetch, output int cycles);
    bit seen;
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 300) begin
      step();
      cycles++;
      seen = fetch ? bus.if_ready : bus.mem_ready;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no ready in %0d cycles, required",
               fetch ? "fetch" : "data", cycles);
    end
  endtask

  task automatic check_zero(input string p);
    check({p, "_ram_en"},    32'(bus.ram_en), 0);
    check({p, "_ram_we"},    32'(bus.ram_we), 0);
    check({p, "_if_ready"},  32'(bus.if_ready), 0);
    check({p, "_mem_ready"}, 32'(bus.mem_ready), 0);
    check({p, "_err"},       32'(bus.err), 0);
    check({p, "_if_rdata"},  bus.if_rdata, 0);
    check({p, "_mem_rdata"}, bus.mem_rdata, 0);
    check({p, "_ram_addr"},  bus.ram_addr, 0);
    check({p, "_ram_wdata"}, bus.ram_wdata, 0);
  endtask

  task automatic fetch_seq(input int n);
    int gap, cyc;
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 4);
      repeat (gap) step();
      a = 32'h1000 | 32'($urandom_range(0, 63) << 2);
      bus.if_addr = a;
      bus.if_req  = 1'b1;
      if_q.push_back(rom(a));
      wait_ready(1'b1, cyc);
      bus.if_req = 1'b0;
    end
  endtask

  task automatic data_seq(input int n);
    int gap, cyc;
    logic [31:0] a, d;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 4);
      repeat (gap) step();
      a = 32'($urandom_range(0, 15) << 2);
      bus.mem_addr = a;
      if ($urandom_range(0, 2) == 0) begin
        d = $urandom;
        bus.mem_wdata = d;
        bus.mem_write = 1'b1;
        mem_q.push_back(last_rd);
        ref_mem[a[5:2]] = d;
      end else begin
        bus.mem_read = 1'b1;
        last_rd = ref_mem[a[5:2]];
        mem_q.push_back(last_rd);
      end
      wait_ready(1'b0, cyc);
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("dual_ready", 32'(bus.if_ready & bus.mem_ready), 0);
      if (!bus.ram_en) check("we_without_en", 32'(bus.ram_we), 0);
      if (bus.if_ready) begin
        if (if_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL if_unexpected: if_ready=1, required 0");
        end else begin
          check("if_rdata", bus.if_rdata, if_q.pop_front());
        end
      end
      if (bus.mem_ready) begin
        if (mem_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL mem_unexpected: mem_ready=1, required 0");
        end else begin
          check("mem_rdata", bus.mem_rdata, mem_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int grants, guard, cyc;
    bit is_f;
    reset         = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    last_rd       = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    repeat (3) step();
    check_zero("reset");
    reset = 1'b0;
    repeat (2) step();

    bus.if_addr = 32'h1010;
    bus.if_req  = 1'b1;
    if_q.push_back(rom(32'h1010));
    step();
    check("fetch_c1_en", 32'(bus.ram_en), 1);
    check("fetch_c1_addr", bus.ram_addr, 32'h1010);
    check("fetch_c1_we", 32'(bus.ram_we), 0);
    step();
    check("fetch_c2_en", 32'(bus.ram_en), 0);
    step();
    check("fetch_c3_ready", 32'(bus.if_ready), 0);
    step();
    check("fetch_c4_ready", 32'(bus.if_ready), 1);
    bus.if_req = 1'b0;
    step();
    check("fetch_c5_ready", 32'(bus.if_ready), 0);

    bus.mem_addr  = 32'h20;
    bus.mem_wdata = 32'h55;
    bus.mem_write = 1'b1;
    mem_q.push_back(last_rd);
    ref_mem[8] = 32'h55;
    step();
    check("wr_c1_en", 32'(bus.ram_en), 1);
    check("wr_c1_we", 32'(bus.ram_we), 1);
    check("wr_c1_wdata", bus.ram_wdata, 32'h55);
    check("wr_c1_addr", bus.ram_addr, 32'h20);
    step();
    check("wr_c2_ready", 32'(bus.mem_ready), 1);
    bus.mem_write = 1'b0;
    step();
    check("wr_c3_we", 32'(bus.ram_we), 0);
    check("wr_c3_ready", 32'(bus.mem_ready), 0);

    bus.mem_addr = 32'h20;
    bus.mem_read = 1'b1;
    last_rd = ref_mem[8];
    mem_q.push_back(last_rd);
    step();
    bus.mem_addr = 32'h3C;
    check("rd_c1_ready", 32'(bus.mem_ready), 0);
    step();
    check("rd_c2_ready", 32'(bus.mem_ready), 0);
    step();
    check("rd_c3_ready", 32'(bus.mem_ready), 0);
    step();
    check("rd_c4_ready", 32'(bus.mem_ready), 1);
    bus.mem_read = 1'b0;
    step();

    bus.if_addr  = 32'h2000;
    bus.if_req   = 1'b1;
    bus.mem_addr = 32'h24;
    bus.mem_read = 1'b1;
    grants = 0;
    guard  = 0;
    while (grants < 8 && guard < 200) begin
      step();
      guard++;
      if (bus.ram_en) begin
        is_f = (bus.ram_addr == 32'h2000);
        check("grant_order", 32'(is_f),
              32'(grants % (SMAX + 1) == SMAX));
        if (is_f) begin
          if_q.push_back(rom(32'h2000));
        end else begin
          last_rd = ref_mem[9];
          mem_q.push_back(last_rd);
        end
        grants++;
        if (grants == 8) begin
          bus.if_req   = 1'b0;
          bus.mem_read = 1'b0;
        end
      end
    end
    check("grant_count", 32'(grants), 8);
    repeat (8) step();
    check("no_err_yet", 32'(bus.err), 0);

    bus.mem_addr  = 32'h28;
    bus.mem_wdata = 32'h77;
    bus.mem_read  = 1'b1;
    bus.mem_write = 1'b1;
    mem_q.push_back(last_rd);
    ref_mem[10] = 32'h77;
    step();
    check("both_c1_we", 32'(bus.ram_we), 1);
    step();
    check("both_c2_ready", 32'(bus.mem_ready), 1);
    check("both_c2_err", 32'(bus.err), 1);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    repeat (3) step();
    check("err_sticky", 32'(bus.err), 1);

    bus.if_addr = 32'h1030;
    bus.if_req  = 1'b1;
    if_q.push_back(rom(32'h1030));
    step();
    check("rst_c1_en", 32'(bus.ram_en), 1);
    step();
    reset = 1'b1;
    #1;
    check_zero("rst_async");
    if_q.delete();
    last_rd = '0;
    repeat (2) step();
    reset = 1'b0;
    step();
    check("post_rst_en", 32'(bus.ram_en), 1);
    check("post_rst_addr", bus.ram_addr, 32'h1030);
    if_q.push_back(rom(32'h1030));
    wait_ready(1'b1, cyc);
    check("post_rst_latency", 32'(cyc), 32'(LAT + 1));
    bus.if_req = 1'b0;
    step();

    fork
      fetch_seq(40);
      data_seq(60);
    join
    repeat (10) step();
    check("if_q_empty", 32'(if_q.size()), 0);
    check("mem_q_empty", 32'(mem_q.size()), 0);
    check("final_err", 32'(bus.err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 2, cycles from RAM read issue to valid ram_rdata; legal range 1..15.
REQ-002 Parameter STARVE_MAX, default 3, consecutive data grants allowed while a fetch is pending; legal range 1..15.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 if_req  in  1  fetch request, held until if_ready.
REQ-006 if_addr  in  32  fetch address.
REQ-007 if_rdata  out  32  fetched instruction, valid while if_ready=1.
REQ-008 if_ready  out  1  one-cycle fetch completion pulse.
REQ-009 mem_read  in  1  data read request, held until mem_ready.
REQ-010 mem_write  in  1  data write request, held until mem_ready.
REQ-011 mem_addr  in  32  data address.
REQ-012 mem_wdata  in  32  write data.
REQ-013 mem_rdata  out  32  read data, valid while mem_ready=1.
REQ-014 mem_ready  out  1  one-cycle data completion pulse.
REQ-015 ram_en  out  1  single-port RAM access strobe.
REQ-016 ram_we  out  1  RAM write enable, only with ram_en.
REQ-017 ram_addr  out  32  RAM address.
REQ-018 ram_wdata  out  32  RAM write data.
REQ-019 ram_rdata  in  32  RAM read data, valid LATENCY cycles after ram_en.
REQ-020 err  out  1  sticky protocol error flag.

Function
REQ-021 All outputs registered; FSM states IDLE, ISSUE, WAIT, DONE.
REQ-022 IDLE: arbitrate pending requests at end of cycle and latch winner's owner, addr, wdata, rd/wr; go ISSUE; no request -> stay IDLE.
REQ-023 Priority: data over fetch, except fetch wins when streak counter == STARVE_MAX and both pending.
REQ-024 Streak counter: +1 on data grant while if_req=1; cleared on fetch grant or when if_req=0 at arbitration; saturates at STARVE_MAX.
REQ-025 ISSUE (exactly 1 cycle): ram_en=1, ram_addr/ram_wdata/ram_we from latched request; read -> WAIT; write -> DONE.
REQ-026 WAIT: exactly LATENCY cycles, ram_en=0; ram_rdata captured on the last WAIT cycle; then DONE.
REQ-027 DONE (exactly 1 cycle): owner's ready=1 with captured rdata (writes: rdata unchanged); then IDLE.
REQ-028 Read latency: request seen in IDLE at cycle 0 -> ready at cycle LATENCY+2; write -> ready at cycle 2; next arbitration earliest in cycle after DONE.
REQ-029 Requests sampled only in IDLE; address/data changes after grant ignored.
REQ-030 Request withdrawn before its ready: access completes, ready still pulses, no err.
REQ-031 mem_read and mem_write both high at arbitration: handled as write, err set to 1 until reset.
REQ-032 Only one of if_ready/mem_ready high in any cycle; ram_we=0 whenever ram_en=0.
REQ-033 ram_addr/ram_wdata/ram_we hold last values outside ISSUE; ram_en alone qualifies them.

Reset
REQ-034 reset=1 forces IDLE immediately: ram_en, ram_we, if_ready, mem_ready, err = 0; if_rdata, mem_rdata, ram_addr, ram_wdata = 0; streak = 0.
REQ-035 Reset mid-access abandons the access; no ready pulse afterward; arbitration resumes first rising edge after reset deasserts.

Verification (LATENCY=2, STARVE_MAX=3)
REQ-036 if_req=1, if_addr=0x10 at cycle 0, ram_rdata=0xDEADBEEF in cycle 3 -> ram_en=1, ram_addr=0x10 in cycle 1; if_ready=1, if_rdata=0xDEADBEEF in cycle 4 only.
REQ-037 mem_write=1, addr=0x20, wdata=0x55 at cycle 0 -> ram_en=ram_we=1, ram_wdata=0x55 in cycle 1; mem_ready=1 in cycle 2; ram_we=0 in cycle 3.
REQ-038 if_req and mem_read both held high continuously -> grant order data, data, data, fetch, data...; no two ready pulses in one cycle.
REQ-039 mem_read=mem_write=1 at cycle 0 -> write performed, mem_ready in cycle 2, err=1 from then until reset.
REQ-040 reset asserted in WAIT of a fetch -> all outputs 0 same cycle, no if_ready; after release with if_req held -> fresh ISSUE one cycle after the first post-reset edge.
